// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-bus channel between NUM_MASTERS requesters.
// The winner holds the downstream bus until ready or an optional timeout abort.
module rggen_register_access_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int TIMEOUT       = 16
)(
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NUM_MASTERS-1:0]                 i_req_valid,
  input  logic [NUM_MASTERS-1:0]                 i_req_write,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]       i_req_write_data,
  input  logic [NUM_MASTERS*BUS_WIDTH/8-1:0]     i_req_strobe,
  output logic [NUM_MASTERS-1:0]                 o_req_ready,
  output logic [1:0]                             o_rsp_status,
  output logic [BUS_WIDTH-1:0]                   o_rsp_read_data,
  output logic [NUM_MASTERS-1:0]                 o_grant,
  output logic                                   o_bus_valid,
  output logic                                   o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]               o_bus_address,
  output logic [BUS_WIDTH-1:0]                   o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]                 o_bus_strobe,
  input  logic                                   i_bus_ready,
  input  logic [1:0]                             i_bus_status,
  input  logic [BUS_WIDTH-1:0]                   i_bus_read_data
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int BW = BUS_WIDTH;
  localparam int SW = BUS_WIDTH / 8;
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] address;
    logic [BW-1:0] write_data;
    logic [SW-1:0] strobe;
  } req_t;

  state_e                  state;
  req_t [NUM_MASTERS-1:0]  req;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           grant_idx;
  logic [IW-1:0]           win_idx;
  logic                    win_found;
  logic                    done;
  logic                    timeout_hit;
  logic                    finish;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req
    assign req[m] = {i_req_write[m], i_req_address[AW*m +: AW],
                     i_req_write_data[BW*m +: BW], i_req_strobe[SW*m +: SW]};
  end

  // Search starts one past the previous owner, so the previous owner is last in line.
  always_comb begin
    logic [IW-1:0] idx;
    idx       = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_MASTERS);
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_timeout
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] to_cnt;

    always_ff @(posedge i_clk) begin
      if (i_rst || state == IDLE) to_cnt <= '0;
      else if (!i_bus_ready)      to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state == BUSY) && !i_bus_ready && (to_cnt == CW'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  assign done   = (state == BUSY) && i_bus_ready;
  assign finish = done || timeout_hit;

  // Bus ready takes precedence over an abort landing in the same cycle.
  assign o_req_ready     = finish ? o_grant : '0;
  assign o_rsp_status    = done ? i_bus_status : (timeout_hit ? 2'b11 : 2'b00);
  assign o_rsp_read_data = done ? i_bus_read_data : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      o_grant          <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
      grant_idx        <= '0;
      last_grant       <= IW'(NUM_MASTERS - 1);
    end else begin
      unique case (state)
        IDLE: if (win_found) begin
          state            <= BUSY;
          o_grant          <= (NUM_MASTERS)'(1) << win_idx;
          grant_idx        <= win_idx;
          o_bus_valid      <= 1'b1;
          o_bus_write      <= req[win_idx].write;
          o_bus_address    <= req[win_idx].address;
          o_bus_write_data <= req[win_idx].write_data;
          o_bus_strobe     <= req[win_idx].strobe;
        end
        BUSY: if (finish) begin
          state            <= IDLE;
          o_grant          <= '0;
          o_bus_valid      <= 1'b0;
          o_bus_write      <= 1'b0;
          o_bus_address    <= '0;
          o_bus_write_data <= '0;
          o_bus_strobe     <= '0;
          last_grant       <= grant_idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Randomized bench: requesters and a bus responder feed a scoreboard checked by a negedge monitor.
module tb_rggen_register_access_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [N-1:0]      i_req_valid, i_req_write;
  logic [N*AW-1:0]   i_req_address;
  logic [N*BW-1:0]   i_req_write_data;
  logic [N*SW-1:0]   i_req_strobe;
  logic [N-1:0]      o_req_ready, o_grant;
  logic [1:0]        o_rsp_status, i_bus_status;
  logic [BW-1:0]     o_rsp_read_data, o_bus_write_data, i_bus_read_data;
  logic              o_bus_valid, o_bus_write, i_bus_ready;
  logic [AW-1:0]     o_bus_address;
  logic [SW-1:0]     o_bus_strobe;

  rggen_register_access_arbiter #(
    .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_address(i_req_address),
    .i_req_write_data(i_req_write_data), .i_req_strobe(i_req_strobe),
    .o_req_ready(o_req_ready), .o_rsp_status(o_rsp_status), .o_rsp_read_data(o_rsp_read_data),
    .o_grant(o_grant), .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write),
    .o_bus_address(o_bus_address), .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
    .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            m;
    logic [1:0]    st;
    logic [BW-1:0] d;
    longint        due;
  } exp_t;

  exp_t            q[$];
  int              checks = 0, errors = 0;
  longint          cyc = 0;
  logic            en = 1'b0, resp_hold = 1'b0;
  logic [N-1:0]    force_req = '0, ready_seen = '0;
  int              rr_last = N - 1;

  // Previous-negedge view of the bus, used by the responder's arbitration model.
  logic [N-1:0]    req_snap = '0, wr_snap = '0, rdy_snap = '0;
  logic [N*AW-1:0] addr_snap = '0;
  logic [N*BW-1:0] data_snap = '0;
  logic [N*SW-1:0] strb_snap = '0;
  logic            bv_snap = 1'b0, rst_snap = 1'b1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Requesters: hold each request until its ready pulse, then maybe issue a new one at once.
  initial begin
    i_req_valid = '0; i_req_write = '0; i_req_address = '0;
    i_req_write_data = '0; i_req_strobe = '0;
    forever begin
      @(posedge i_clk); #1;
      for (int m = 0; m < N; m++) begin
        if (i_req_valid[m] && ready_seen[m]) i_req_valid[m] = 1'b0;
        if (!i_req_valid[m] && (force_req[m] || (en && $urandom_range(0, 3) == 0))) begin
          i_req_valid[m]              = 1'b1;
          i_req_write[m]              = 1'($urandom);
          i_req_address[m*AW +: AW]   = AW'($urandom);
          i_req_write_data[m*BW +: BW] = $urandom;
          i_req_strobe[m*SW +: SW]    = SW'($urandom);
          force_req[m]                = 1'b0;
        end
      end
    end
  end

  // Responder: models arbitration, checks the granted request, plans the reply, pushes the expectation.
  initial begin
    int busy_j, plan, w, k;
    logic [1:0]    st;
    logic [BW-1:0] dt;
    logic [63:0]   cur_exp;
    busy_j = 0; plan = 0; cur_exp = '0;
    i_bus_ready = 1'b0; i_bus_status = '0; i_bus_read_data = '0;
    forever begin
      @(posedge i_clk); #2;
      i_bus_ready     = 1'b0;
      i_bus_status    = 2'($urandom);
      i_bus_read_data = $urandom;
      if (!rst_snap) begin
        if (!bv_snap) check("busy_start", o_bus_valid, req_snap != '0);
        else          check("busy_end_bubble", o_bus_valid, rdy_snap == '0);
      end
      if (!o_bus_valid) begin
        busy_j = 0;
        i_bus_ready = ($urandom_range(0, 7) == 0);
      end else begin
        if (busy_j == 0) begin
          check("grant_has_request", req_snap != '0, 1'b1);
          w = rr_pick(req_snap, rr_last);
          if (w < 0) w = 0;
          rr_last = w;
          cur_exp = {onehot(w), wr_snap[w], addr_snap[w*AW +: AW],
                     data_snap[w*BW +: BW], strb_snap[w*SW +: SW]};
          check("bus_request", {o_grant, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe}, cur_exp);
          plan = resp_hold ? 1000 : $urandom_range(1, 6);
          st = 2'($urandom);
          dt = $urandom;
          k  = (plan <= TO) ? plan : TO;
          if (plan <= TO) q.push_back('{m: w, st: st, d: dt, due: cyc + k - 1});
          else            q.push_back('{m: w, st: 2'b11, d: '0, due: cyc + k - 1});
        end else begin
          check("bus_hold", {o_grant, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe}, cur_exp);
        end
        busy_j++;
        if (busy_j == plan) begin
          i_bus_ready = 1'b1; i_bus_status = st; i_bus_read_data = dt;
        end
      end
    end
  end

  // Monitor: snapshot inputs/outputs and score every response cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      req_snap = i_req_valid; wr_snap = i_req_write; addr_snap = i_req_address;
      data_snap = i_req_write_data; strb_snap = i_req_strobe;
      bv_snap = o_bus_valid; rdy_snap = o_req_ready; rst_snap = i_rst;
      ready_seen = i_rst ? '0 : o_req_ready;
      if (i_rst) begin
        q.delete();
        rr_last = N - 1;
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("response", {o_req_ready, o_rsp_status, o_rsp_read_data}, {onehot(e.m), e.st, e.d});
      end else begin
        check("no_response", {o_req_ready, o_rsp_status, o_rsp_read_data}, 64'd0);
      end
    end
  end

  task automatic wait_quiet(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge i_clk); #3;
      ok = (i_req_valid == '0) && !o_bus_valid;
    end
    check(nm, ok, 1'b1);
  endtask

  task automatic wait_busy(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge i_clk); #3;
      ok = o_bus_valid;
    end
    check(nm, ok, 1'b1);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_state", {o_grant, o_bus_valid, o_bus_write, o_bus_address,
                          o_bus_write_data, o_bus_strobe, o_req_ready}, 64'd0);
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    en    = 1'b1;
    repeat (800) @(posedge i_clk);
    #3 en = 1'b0;
    wait_quiet("drain_random");

    // Reset in the second BUSY cycle of an M1 transfer, then M0 and M1 compete.
    force_req = 3'b010;
    resp_hold = 1'b1;
    wait_busy("m1_busy");
    check("m1_granted", o_grant, 3'b010);
    @(posedge i_clk); #3;
    i_rst     = 1'b1;
    force_req = 3'b001;
    resp_hold = 1'b0;
    @(posedge i_clk); #3;
    check("post_reset_outputs", {o_grant, o_bus_valid, o_bus_write, o_bus_address,
                                 o_bus_write_data, o_bus_strobe, o_req_ready}, 64'd0);
    i_rst = 1'b0;
    wait_busy("post_reset_busy");
    check("m0_first_after_reset", o_grant, 3'b001);
    wait_quiet("drain_final");
    repeat (3) @(posedge i_clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
